// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, F-group function codes, ALU operations and
// the decoded control word consumed by the datapath.
package cpu_pkg;
    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_BGT  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_ANDI = 4'h8;
    localparam logic [3:0] OP_ORI  = 4'h9;
    localparam logic [3:0] OP_LBU  = 4'hA;
    localparam logic [3:0] OP_SB   = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;
    localparam logic [3:0] OP_FUNC = 4'hF;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_MUL  = 4'h4;
    localparam logic [3:0] FN_DIV  = 4'h5;
    localparam logic [3:0] FN_MOV  = 4'h7;
    localparam logic [3:0] FN_SWAP = 4'h8;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_MUL    = 3'd2,
        ALU_DIV    = 3'd3,
        ALU_PASS_B = 3'd4,
        ALU_AND    = 3'd5,
        ALU_OR     = 3'd6,
        ALU_RSVD   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic    w2_addr_src;
        logic    w2_en;
        logic    write_back;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
        logic    memory_read;
        logic    memory_write;
        logic    byte_select;
        logic    err;
        logic    alu_op2_src;
    } ctrl_t;
endpackage

// File: rtl/control_if.sv
// Instruction in, registered control word out, between fetch stage and control.
interface control_if;
    logic [15:0] instruction;
    logic        w2_addr_src;
    logic        w2_en;
    logic        write_back;
    logic        mem_to_reg;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        memory_read;
    logic        memory_write;
    logic        byte_select;
    logic        err;
    logic        alu_op2_src;

    modport master (
        output instruction,
        input  w2_addr_src, w2_en, write_back, mem_to_reg, alu_src, alu_op,
               memory_read, memory_write, byte_select, err, alu_op2_src
    );

    modport slave (
        input  instruction,
        output w2_addr_src, w2_en, write_back, mem_to_reg, alu_src, alu_op,
               memory_read, memory_write, byte_select, err, alu_op2_src
    );
endinterface

// File: rtl/control_decode.sv
// Pure combinational instruction decoder; anything not set for an opcode stays 0.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_HALT, OP_JMP: ;
            OP_BGT, OP_BLT, OP_BEQ: begin
                ctrl.alu_op      = ALU_SUB;
                ctrl.alu_op2_src = 1'b1;
            end
            OP_ANDI: begin
                ctrl.write_back = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_AND;
            end
            OP_ORI: begin
                ctrl.write_back = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_OR;
            end
            OP_LBU, OP_LW: begin
                ctrl.memory_read = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.write_back  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.byte_select = (opcode == OP_LBU);
            end
            OP_SB, OP_SW: begin
                ctrl.memory_write = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.byte_select  = (opcode == OP_SB);
            end
            OP_FUNC: begin
                case (funct)
                    FN_ADD: ctrl.write_back = 1'b1;
                    FN_SUB: begin
                        ctrl.write_back = 1'b1;
                        ctrl.alu_op     = ALU_SUB;
                    end
                    FN_MUL, FN_DIV: begin
                        // Product/quotient high half goes to R0 via port 2
                        ctrl.write_back = 1'b1;
                        ctrl.w2_en      = 1'b1;
                        ctrl.alu_op     = (funct == FN_MUL) ? ALU_MUL : ALU_DIV;
                    end
                    FN_MOV: begin
                        ctrl.write_back = 1'b1;
                        ctrl.alu_op     = ALU_PASS_B;
                    end
                    FN_SWAP: begin
                        ctrl.write_back  = 1'b1;
                        ctrl.w2_en       = 1'b1;
                        ctrl.w2_addr_src = 1'b1;
                        ctrl.alu_op      = ALU_PASS_B;
                    end
                    default: ctrl.err = 1'b1;
                endcase
            end
            default: ctrl.err = 1'b1;
        endcase
    end
endmodule

// File: rtl/control.sv
// Control unit: combinational decode followed by one output register stage.
module control
    import cpu_pkg::*;
(
    input logic      clk,
    input logic      rst,
    control_if.slave bus
);
    ctrl_t dec;
    ctrl_t q;

    control_decode u_decode (
        .opcode (bus.instruction[15:12]),
        .funct  (bus.instruction[3:0]),
        .ctrl   (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= dec;
    end

    assign bus.w2_addr_src  = q.w2_addr_src;
    assign bus.w2_en        = q.w2_en;
    assign bus.write_back   = q.write_back;
    assign bus.mem_to_reg   = q.mem_to_reg;
    assign bus.alu_src      = q.alu_src;
    assign bus.alu_op       = q.alu_op;
    assign bus.memory_read  = q.memory_read;
    assign bus.memory_write = q.memory_write;
    assign bus.byte_select  = q.byte_select;
    assign bus.err          = q.err;
    assign bus.alu_op2_src  = q.alu_op2_src;
endmodule

// File: tb/tb_control.sv
// Directed bench for control: every-cycle model compare plus literal spot checks.
module tb_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [12:0] exp_q = '0;
    bit   armed = 1'b0;

    control_if bus ();
    control dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Bit order: w2s w2e wb m2r asrc op[2:0] mr mw bs err o2
    function automatic logic [12:0] pack(bit w2s, bit w2e, bit wb, bit m2r, bit asrc,
                                         int op, bit mr, bit mw, bit bs, bit er, bit o2);
        logic [2:0] o;
        o = op[2:0];
        return {w2s, w2e, wb, m2r, asrc, o, mr, mw, bs, er, o2};
    endfunction

    // Reference decode written straight from the instruction table
    function automatic logic [12:0] model(logic [15:0] ins);
        int opc, fn;
        opc = int'(ins[15:12]);
        fn  = int'(ins[3:0]);
        if (opc == 0 || opc == 1)            return '0;
        if (opc >= 4 && opc <= 6)            return pack(0,0,0,0,0,1,0,0,0,0,1);
        if (opc == 8)                        return pack(0,0,1,0,1,5,0,0,0,0,0);
        if (opc == 9)                        return pack(0,0,1,0,1,6,0,0,0,0,0);
        if (opc == 10)                       return pack(0,0,1,1,1,0,1,0,1,0,0);
        if (opc == 11)                       return pack(0,0,0,0,1,0,0,1,1,0,0);
        if (opc == 12)                       return pack(0,0,1,1,1,0,1,0,0,0,0);
        if (opc == 13)                       return pack(0,0,0,0,1,0,0,1,0,0,0);
        if (opc == 15) begin
            if (fn == 0) return pack(0,0,1,0,0,0,0,0,0,0,0);
            if (fn == 1) return pack(0,0,1,0,0,1,0,0,0,0,0);
            if (fn == 4) return pack(0,1,1,0,0,2,0,0,0,0,0);
            if (fn == 5) return pack(0,1,1,0,0,3,0,0,0,0,0);
            if (fn == 7) return pack(0,0,1,0,0,4,0,0,0,0,0);
            if (fn == 8) return pack(1,1,1,0,0,4,0,0,0,0,0);
        end
        return pack(0,0,0,0,0,0,0,0,0,1,0);
    endfunction

    function automatic logic [12:0] outs();
        return {bus.w2_addr_src, bus.w2_en, bus.write_back, bus.mem_to_reg, bus.alu_src,
                bus.alu_op, bus.memory_read, bus.memory_write, bus.byte_select, bus.err,
                bus.alu_op2_src};
    endfunction

    task automatic chk(string name, logic [12:0] act, logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_q = rst ? 13'd0 : model(bus.instruction);
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model", outs(), exp_q);
            chk("rd_wr_excl", {12'd0, bus.memory_read & bus.memory_write}, 13'd0);
            chk("w2_implies_wb", {12'd0, bus.w2_en & ~bus.write_back}, 13'd0);
        end
    end

    // Present an instruction, take one edge, settle past it
    task automatic apply(logic [15:0] ins, logic r);
        bus.instruction = ins;
        rst = r;
        @(posedge clk);
        #2;
    endtask

    localparam logic [12:0] E_F004 = 13'b0_1_1_0_0_010_0_0_0_0_0;
    localparam logic [12:0] E_F008 = 13'b1_1_1_0_0_100_0_0_0_0_0;
    localparam logic [12:0] E_A000 = 13'b0_0_1_1_1_000_1_0_1_0_0;
    localparam logic [12:0] E_D000 = 13'b0_0_0_0_1_000_0_1_0_0_0;
    localparam logic [12:0] E_BR   = 13'b0_0_0_0_0_001_0_0_0_0_1;
    localparam logic [12:0] E_ERR  = 13'b0_0_0_0_0_000_0_0_0_1_0;
    localparam logic [12:0] E_C000 = 13'b0_0_1_1_1_000_1_0_0_0_0;

    initial begin
        logic [15:0] brs [3];
        logic [15:0] bad [3];
        brs = '{16'h5000, 16'h4000, 16'h6000};
        bad = '{16'hF003, 16'h7000, 16'hE000};

        bus.instruction = 16'hF000;
        rst = 1'b1;
        apply(16'hF000, 1'b1);
        apply(16'hF000, 1'b1);
        chk("reset_zero", outs(), 13'd0);

        apply(16'hF004, 1'b0);
        chk("F004_mul", outs(), E_F004);
        apply(16'hF008, 1'b0);
        chk("F008_swap", outs(), E_F008);
        apply(16'hA000, 1'b0);
        chk("A000_lbu", outs(), E_A000);
        apply(16'hD000, 1'b0);
        chk("D000_sw", outs(), E_D000);
        foreach (brs[i]) begin
            apply(brs[i], 1'b0);
            chk("branch", outs(), E_BR);
        end
        apply(16'h1000, 1'b0);
        chk("jump_zero", outs(), 13'd0);
        apply(16'h0000, 1'b0);
        chk("halt_zero", outs(), 13'd0);

        // Illegal codes: outputs must hold old value until the edge
        foreach (bad[i]) begin
            bus.instruction = bad[i];
            #1;
            chk("no_early_change", outs(), (i == 0) ? 13'd0 : E_ERR);
            apply(bad[i], 1'b0);
            chk("illegal", outs(), E_ERR);
        end

        apply(16'hC000, 1'b0);
        chk("C000_lw", outs(), E_C000);
        apply(16'hC000, 1'b1);
        chk("mid_reset", outs(), 13'd0);
        apply(16'hC000, 1'b0);
        chk("post_reset_lw", outs(), E_C000);

        // Sweep every opcode and every F function through the model compare
        for (int op = 0; op < 16; op++) apply({op[3:0], 8'h5A, 4'h3}, 1'b0);
        for (int fn = 0; fn < 16; fn++) apply({4'hF, 8'hA5, fn[3:0]}, 1'b0);
        apply(16'h9000, 1'b0);
        chk("ori", outs(), 13'b0_0_1_0_1_110_0_0_0_0_0);
        apply(16'hB000, 1'b0);
        chk("sb", outs(), 13'b0_0_0_0_1_000_0_1_1_0_0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 instruction  input  16  current instruction; [15:12] opcode, [3:0] function code when opcode==F.
REQ-006 w2_addr_src  output  1  second-write-port address select: 0 = R0, 1 = op2 register field.
REQ-007 w2_en  output  1  second register-file write enable.
REQ-008 write_back  output  1  primary register-file write enable.
REQ-009 mem_to_reg  output  1  write-back data from memory (1) or ALU (0).
REQ-010 alu_src  output  1  ALU operand B: 0 = register, 1 = sign/zero-extended immediate.
REQ-011 alu_op  output  3  ALU operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 PASS_B, 5 AND, 6 OR, 7 reserved.
REQ-012 memory_read  output  1  data-memory read strobe.
REQ-013 memory_write  output  1  data-memory write strobe.
REQ-014 byte_select  output  1  byte (1) vs word (0) memory access.
REQ-015 err  output  1  illegal opcode/function flag.
REQ-016 alu_op2_src  output  1  compare operand from R0 (1) vs op2 register (0).

Function
REQ-017 All outputs SHALL be registered; the decode of instruction sampled at rising edge N appears on outputs after edge N; latency exactly 1 cycle.
REQ-018 Every output not listed as 1 for a given instruction SHALL be 0; alu_op defaults to ADD (0).
REQ-019 F/0 signed add: write_back=1, alu_op=ADD.
REQ-020 F/1 signed subtract: write_back=1, alu_op=SUB.
REQ-021 F/4 signed multiply: write_back=1, w2_en=1, w2_addr_src=0, alu_op=MUL.
REQ-022 F/5 signed divide: write_back=1, w2_en=1, w2_addr_src=0, alu_op=DIV.
REQ-023 F/7 move: write_back=1, alu_op=PASS_B.
REQ-024 F/8 swap: write_back=1, w2_en=1, w2_addr_src=1, alu_op=PASS_B.
REQ-025 F with any other function code (2,3,6,9-F): err=1, all other outputs 0.
REQ-026 8 AND immediate: write_back=1, alu_src=1, alu_op=AND.
REQ-027 9 OR immediate: write_back=1, alu_src=1, alu_op=OR.
REQ-028 A load byte unsigned: memory_read=1, mem_to_reg=1, write_back=1, byte_select=1, alu_src=1, alu_op=ADD.
REQ-029 B store byte: memory_write=1, byte_select=1, alu_src=1, alu_op=ADD.
REQ-030 C load word: memory_read=1, mem_to_reg=1, write_back=1, alu_src=1, alu_op=ADD.
REQ-031 D store word: memory_write=1, alu_src=1, alu_op=ADD.
REQ-032 4 BGT, 5 BLT, 6 BEQ: alu_op=SUB, alu_op2_src=1; no register or memory write.
REQ-033 1 jump and 0 halt: all outputs 0, err=0.
REQ-034 Opcodes 2, 3, 7, E: err=1, all other outputs 0.
REQ-035 memory_read and memory_write SHALL never both be 1; w2_en=1 implies write_back=1.
REQ-036 Outputs SHALL depend only on the most recently sampled instruction; no other state.

Reset
REQ-037 While rst=1 at a rising edge, all outputs SHALL be 0 on the next cycle, including alu_op=0 and err=0.
REQ-038 Reset asserted mid-stream overrides decode at that edge; the first decode after rst is deasserted appears one cycle after the first edge with rst=0.

Structure
REQ-039 Opcode constants, F-function constants, and alu_op encodings SHALL live in a shared package (cpu_pkg) shared with the ALU and datapath.
REQ-040 The block SHALL be split into one combinational sub-module, control_decode, plus an output register stage in control.

Verification
REQ-041 rst=1 for 2 cycles with instruction=F000 -> all outputs 0.
REQ-042 F004, one edge -> write_back=1, w2_en=1, w2_addr_src=0, alu_op=2, err=0; F008 -> w2_addr_src=1, alu_op=4.
REQ-043 A000 -> memory_read=1, mem_to_reg=1, write_back=1, byte_select=1, alu_src=1; D000 -> memory_write=1, alu_src=1, byte_select=0.
REQ-044 5000, 4000, 6000 -> alu_op=1, alu_op2_src=1, write_back=0; 1000 and 0000 -> all outputs 0.
REQ-045 F003, 7000, E000 -> err=1, all other outputs 0; outputs change one edge after the instruction changes, not before.
REQ-046 Assert rst while instruction=C000 -> outputs 0 next cycle; release rst -> load-word decode one cycle later.
